uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have one parameter, OVERSAMPLE, default 16, giving the number of tick pulses per bit period; it SHALL be a power of two, 8 or greater.
REQ-002 The module SHALL have one parameter, SYNC_STAGES, default 2, giving the number of flops in the rx input synchronizer; it SHALL be 2 or greater.
REQ-003 Port clk SHALL be an input of width 1: the single system clock, with all logic on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: reset is asynchronous and active-high.
REQ-005 Port tick SHALL be an input of width 1: a one-clk strobe at OVERSAMPLE times the baud rate, shared with the transmitter's baud generator.
REQ-006 Port rx SHALL be an input of width 1: the asynchronous serial line, which idles high.
REQ-007 Port rx_data SHALL be an output of width 8: the last received byte.
REQ-008 Port o_rx_done SHALL be an output of width 1: a one-clk pulse when a frame completes.
REQ-009 Port o_frame_err SHALL be an output of width 1 and SHALL exist only when UART_RX_FRAME_ERR_EN is defined (see REQ-024).

Function
REQ-010 The frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), with no parity.
REQ-011 rx SHALL pass through the SYNC_STAGES synchronizer, with its flops reset to 1, before any use; "line" below means the synchronized value.
REQ-012 The FSM SHALL have 4 states, IDLE, START, DATA and STOP, held in a registered state with a combinational next-state block.
REQ-013 IDLE: the tick counter and bit counter SHALL be held at 0; line == 0 SHALL cause the transition to START, whether or not tick is asserted.
REQ-014 START: on each tick the counter SHALL increment, and at count == OVERSAMPLE/2-1 the line SHALL be sampled.
- Line still 0: go to DATA with both counters cleared.
- Line 1: treat as a false start and go to IDLE with no output change.
REQ-015 DATA: on each tick, at count == OVERSAMPLE-1 the counter SHALL clear and the line SHALL be shifted into the shift register MSB, shifting right, which places the byte LSB-first.
- The bit counter SHALL then increment.
- After the 8th bit the FSM SHALL go to STOP.
REQ-016 STOP: at tick count == OVERSAMPLE-1 the line SHALL be sampled and the FSM SHALL return to IDLE in the same cycle.
REQ-017 On the STOP sample clock edge, rx_data SHALL load the shift register and o_rx_done SHALL be 1 for exactly one clk.
REQ-018 rx_data SHALL hold its value until the next completed frame.
REQ-019 Without tick, no counter SHALL advance and no sample SHALL be taken; the state SHALL hold.
REQ-020 A falling edge of rx during START, DATA or STOP SHALL NOT restart the frame.
REQ-021 Latency from the synchronized start edge to o_rx_done SHALL be 9.5 bit periods (OVERSAMPLE/2 + 9*OVERSAMPLE ticks), plus up to 1 tick of phase.
REQ-022 Back-to-back frames, whose start bit directly follows the stop bit, SHALL be received without loss, because IDLE detects the start bit on the very next clk.

Reset
REQ-023 While rst is high, the module SHALL hold these values:
- state = IDLE, with all counters and the shift register at 0.
- rx_data = 8'h00.
- o_rx_done = 0 and o_frame_err = 0.
- Synchronizer flops = 1.
A reset mid-frame SHALL abandon the frame with no o_rx_done pulse; reception SHALL resume on the next start edge after release.

Configuration
REQ-024 The macro UART_RX_FRAME_ERR_EN SHALL select between two behaviours.
- Defined: o_frame_err SHALL be registered and updated on the same edge as o_rx_done, as the inverse of the sampled stop bit. It SHALL hold until the next completion, and rx_data SHALL still load.
- Undefined: the o_frame_err port and its logic SHALL be absent, and the stop bit SHALL be sampled but ignored.

Structure
REQ-025 A shared package uart_pkg SHALL hold the following:
- The state encoding: IDLE = 0, START = 1, DATA = 2, STOP = 3.
- DATA_BITS = 8.
- The default OVERSAMPLE = 16.
This package SHALL be common with the transmitter.
REQ-026 One sub-module, uart_rx_sync (the parameterized SYNC_STAGES flop chain with async reset to 1), SHALL be instantiated; all other logic SHALL be flat in uart_rx.

Verification
REQ-027 The bench SHALL cover the following directed scenarios, with tick every 4 clk and OVERSAMPLE=16:
- Frame 0x55 with stop=1 -> a single o_rx_done pulse, rx_data=8'h55, and o_frame_err=0 when enabled.
- Frames 0xA5 then 0x3C back-to-back -> two o_rx_done pulses, 160 ticks apart, with rx_data 8'hA5 then 8'h3C.
- rx low for 4 ticks then high (glitch) -> FSM back in IDLE, no o_rx_done, and rx_data unchanged.
- Frame 0xF0 with stop=0, with UART_RX_FRAME_ERR_EN defined -> o_rx_done pulse, rx_data=8'hF0, and o_frame_err=1.
- rst asserted for 1 clk during data bit 3 of 0x81, then a clean 0x81 frame -> no pulse for the aborted frame, then one pulse with rx_data=8'h81.
- tick held low for 100 clk mid-DATA, then resumed -> the byte is still received correctly, with sampling position unchanged in ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and transmitter: FSM encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line; flops reset to the idle level (1).
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an OVERSAMPLE x baud tick strobe.
// Define UART_RX_FRAME_ERR_EN to add the registered o_frame_err output (inverse of the stop bit).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 o_rx_done
`ifdef UART_RX_FRAME_ERR_EN
  ,output logic                o_frame_err
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic line;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (line)
  );

  uart_state_e          state_q,    state_d;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
  logic                 rx_done_q,  rx_done_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic                 ferr_q,     ferr_d;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d     = ferr_q;
`endif
    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!line) state_d = START;
      end
      // Mid-start-bit check rejects glitches shorter than half a bit.
      START: if (tick) begin
        if (tick_cnt_q == HALF_M1) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = line ? IDLE : DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + CW'(1);
        end
      end
      DATA: if (tick) begin
        if (tick_cnt_q == FULL_M1) begin
          tick_cnt_d = '0;
          shift_d    = {line, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + CW'(1);
        end
      end
      STOP: if (tick) begin
        if (tick_cnt_q == FULL_M1) begin
          tick_cnt_d = '0;
          rx_data_d  = shift_q;
          rx_done_d  = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
          ferr_d     = ~line;
`endif
          state_d    = IDLE;
        end else begin
          tick_cnt_d = tick_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q     <= ferr_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign o_rx_done = rx_done_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign o_frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed scenarios plus randomized 8N1 frames.
module tb_uart_rx;

  localparam int OS   = 16;
  localparam int CLKP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       o_rx_done;
`ifdef UART_RX_FRAME_ERR_EN
  logic       o_frame_err;
`endif

  typedef struct {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t       sb[$];
  time        done_t[$];
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         expected_frames = 0;
  int         tcnt = 0;
  bit         tick_en = 1'b1;
  logic       prev_done = 1'b0;
  logic [7:0] last_byte = 8'h00;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .o_rx_done (o_rx_done)
`ifdef UART_RX_FRAME_ERR_EN
    ,.o_frame_err (o_frame_err)
`endif
  );

  initial forever #(CLKP/2) clk = ~clk;

  // Tick strobe every 4 clk, changed on the falling edge so the DUT sees it stable.
  initial forever begin
    @(negedge clk);
    tcnt++;
    tick = tick_en && (tcnt % 4 == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a completed frame.
  always @(negedge clk) begin
    if (!rst && o_rx_done) begin
      exp_t e;
      done_cnt++;
      done_t.push_back($time);
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got rx_data %0h with no frame expected", rx_data);
      end else begin
        e = sb.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
`ifdef UART_RX_FRAME_ERR_EN
        chk("frame_err", {31'd0, o_frame_err}, {31'd0, e.fe});
`endif
      end
    end
    prev_done = o_rx_done;
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input int pause_bit);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == pause_bit) begin
        wait_ticks(5);
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        tick_en = 1'b1;
        wait_ticks(OS - 5);
      end else begin
        wait_ticks(OS);
      end
    end
    rx = stop;
    if (stop) begin
      wait_ticks(OS);
    end else begin
      // Return high before the end of the bit so the receiver sees a false start, not a new frame.
      wait_ticks(12);
      rx = 1'b1;
      wait_ticks(OS - 12);
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input bit stop);
    exp_t e;
    e.d  = b;
    e.fe = ~stop;
    sb.push_back(e);
    expected_frames++;
    last_byte = b;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_arrival", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  initial begin
    int base;
    logic [7:0] b;
    bit stop;

    repeat (5) @(negedge clk);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_done", {31'd0, o_rx_done}, 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
    chk("reset_frame_err", {31'd0, o_frame_err}, 32'd0);
`endif
    rst = 1'b0;
    wait_ticks(20);

    expect_frame(8'h55, 1'b1);
    send_frame(8'h55, 1'b1, -1);
    wait_done(expected_frames);
    chk("frame_55", {24'd0, rx_data}, 32'h55);
    wait_ticks(8);

    base = done_t.size();
    expect_frame(8'hA5, 1'b1);
    expect_frame(8'h3C, 1'b1);
    send_frame(8'hA5, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    wait_done(expected_frames);
    if (done_t.size() >= base + 2)
      chk("b2b_spacing", 32'(done_t[base+1] - done_t[base]), 32'(160 * 4 * CLKP));
    chk("b2b_last", {24'd0, rx_data}, 32'h3C);
    wait_ticks(8);

    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    chk("glitch_no_done", done_cnt, expected_frames);
    chk("glitch_rx_data", {24'd0, rx_data}, 32'h3C);
    expect_frame(8'h96, 1'b1);
    send_frame(8'h96, 1'b1, -1);
    wait_done(expected_frames);
    wait_ticks(8);

    expect_frame(8'hF0, 1'b0);
    send_frame(8'hF0, 1'b0, -1);
    wait_done(expected_frames);
    chk("frame_F0", {24'd0, rx_data}, 32'hF0);
`ifdef UART_RX_FRAME_ERR_EN
    chk("frame_F0_err", {31'd0, o_frame_err}, 32'd1);
`endif
    wait_ticks(8);

    // Abort 0x81 with a one-clock reset in the middle of data bit 3.
    b = 8'h81;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = b[3];
    wait_ticks(OS / 2);
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    wait_ticks(3 * OS);
    chk("midreset_no_done", done_cnt, expected_frames);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, -1);
    wait_done(expected_frames);
    chk("frame_81", {24'd0, rx_data}, 32'h81);
    wait_ticks(8);

    expect_frame(8'hC3, 1'b1);
    send_frame(8'hC3, 1'b1, 4);
    wait_done(expected_frames);
    chk("tick_pause", {24'd0, rx_data}, 32'hC3);
    wait_ticks(8);

    for (int n = 0; n < 25; n++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      expect_frame(b, stop);
      send_frame(b, stop, -1);
      rx = 1'b1;
      wait_ticks($urandom_range(0, 20));
    end
    wait_done(expected_frames);
    wait_ticks(4);

    chk("sb_empty", sb.size(), 32'd0);
    chk("done_total", done_cnt, expected_frames);
    chk("final_hold", {24'd0, rx_data}, {24'd0, last_byte});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
